ex_mdu: RTL and testbench
=========================

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: mdu_req  input  1  EX holds a valid RV32M instruction (valid & mdu op) this cycle.
REQ-005 SHALL have port: mdu_opcode  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port: mdu_rs1  input  32  operand A (dividend / multiplicand).
REQ-007 SHALL have port: mdu_rs2  input  32  operand B (divisor / multiplier).
REQ-008 SHALL have port: ex_flush  input  1  kill the EX instruction (branch or trap flush).
REQ-009 SHALL have port: ex_hold  input  1  EX is held by a downstream stall (e.g. lsu_stall_req in MEM).
REQ-010 SHALL have port: mdu_stall_req  output  1  request that IF/ID/EX stall while the operation is in progress.
REQ-011 SHALL have port: mdu_done  output  1  mdu_result is valid this cycle.
REQ-012 SHALL have port: mdu_result  output  32  result; EX muxes it into alu_out of the ex2mem pipeline register.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL move IDLE->BUSY when mdu_req=1 and ex_flush=0, and SHALL latch the opcode, the operand signs and the operand magnitudes (unsigned operands as-is).
REQ-015 SHALL stay in BUSY for exactly 32 cycles: a 5-bit counter loads 31 on entry, decrements each cycle, and the FSM moves to DONE when the counter is 0.
REQ-016 SHALL perform one radix-2 step per BUSY cycle: shift-add into a 64-bit product for MUL*, restoring shift-subtract for DIV*/REM*.
REQ-017 SHALL have a fixed latency for every opcode, including special cases: request in IDLE at cycle N, BUSY N+1..N+32, DONE and mdu_done=1 at N+33.
REQ-018 SHALL drive mdu_stall_req = (IDLE & mdu_req & ~ex_flush) | BUSY, combinationally; it SHALL be 0 in DONE.
REQ-019 SHALL return DONE->IDLE when ex_hold=0, and SHALL stay in DONE with mdu_result and mdu_done=1 held stable while ex_hold=1.
REQ-020 SHALL NOT start a new operation from DONE; a new request is accepted only in IDLE.
REQ-021 SHALL produce for MUL the low 32 bits of the product, and for MULH/MULHSU/MULHU the high 32 bits (signed*signed, signed*unsigned, unsigned*unsigned).
REQ-022 SHALL apply signed correction on the DONE transition, without extra cycles: quotient negated if the signs differ, remainder takes the sign of the dividend, product negated per operand signs.
REQ-023 SHALL, on divide by zero, return quotient 0xFFFFFFFF for DIV/DIVU and remainder = rs1 for REM/REMU.
REQ-024 SHALL, on signed overflow (DIV with 0x80000000 / 0xFFFFFFFF), return quotient 0x80000000 and remainder 0 for REM.
REQ-025 SHALL, when ex_flush=1 in any state, force mdu_stall_req=0 and mdu_done=0 that cycle and move to IDLE at the next edge without producing a result.
REQ-026 SHALL give ex_flush priority over ex_hold, and both over mdu_req.
REQ-027 SHALL drive mdu_done=0 in IDLE and BUSY; mdu_result is don't-care outside DONE but SHALL NOT contain X.

Reset
REQ-028 SHALL, while rst=1, immediately (asynchronously) set state IDLE, counter 0, mdu_stall_req=0, mdu_done=0 and mdu_result=0, including when reset is asserted mid-operation.
REQ-029 SHALL leave IDLE only on a request sampled at a clock edge after rst is deasserted.

Verification
REQ-030 SHALL cover: MUL 7 * 0xFFFFFFFD at cycle 0 -> mdu_stall_req=1 for cycles 0..32, mdu_done=1 at cycle 33, result 0xFFFFFFEB.
REQ-031 SHALL cover: MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 * 0x80000000 -> 0x40000000.
REQ-032 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0; DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF.
REQ-033 SHALL cover: DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each at the fixed 33-cycle latency.
REQ-034 SHALL cover: ex_flush at BUSY cycle 10 -> mdu_stall_req=0 that cycle, IDLE next cycle, no mdu_done; then a back-to-back new request completes correctly.
REQ-035 SHALL cover: ex_hold=1 for 3 cycles in DONE -> mdu_done and mdu_result stable for 4 cycles, then IDLE; rst pulse at BUSY cycle 5 -> all outputs 0 immediately, no result.

Source files
------------

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Fixed 32-step radix-2 datapath: shift-add multiply, restoring divide.
module ex_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdu_req,
  input  logic [2:0]      mdu_opcode,
  input  logic [XLEN-1:0] mdu_rs1,
  input  logic [XLEN-1:0] mdu_rs2,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            mdu_stall_req,
  output logic            mdu_done,
  output logic [XLEN-1:0] mdu_result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic                div_zero_q, div_zero_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
    end
  end

  // Next-state: flush beats hold, hold beats a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mdu_req && !ex_flush) state_d = BUSY;
      BUSY: begin
        if (ex_flush)          state_d = IDLE;
        else if (cnt_q == 5'd0) state_d = DONE;
      end
      DONE: if (ex_flush || !ex_hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst gating keeps stall low while reset holds the FSM in IDLE.
  always_comb begin
    mdu_stall_req = !rst && !ex_flush &&
                    (((state_q == IDLE) && mdu_req) || (state_q == BUSY));
    mdu_done      = !rst && !ex_flush && (state_q == DONE);
    mdu_result    = result_q;
  end

  logic              start, last;
  logic              signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_geq;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  always_comb begin
    start = (state_q == IDLE) && (state_d == BUSY);
    last  = (state_q == BUSY) && (state_d == DONE);

    case (mdu_opcode)
      3'd0, 3'd1, 3'd4, 3'd6: begin signed_a = 1'b1; signed_b = 1'b1; end
      3'd2:                   begin signed_a = 1'b1; signed_b = 1'b0; end
      default:                begin signed_a = 1'b0; signed_b = 1'b0; end
    endcase
    neg_a = signed_a && mdu_rs1[XLEN-1];
    neg_b = signed_b && mdu_rs2[XLEN-1];
    mag_a = neg_a ? -mdu_rs1 : mdu_rs1;
    mag_b = neg_b ? -mdu_rs2 : mdu_rs2;

    // acc holds {hi, multiplier} for MUL* and {remainder, dividend/quotient} for DIV*.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_geq   = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    if (op_q[2])
      acc_step = {(div_geq ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_geq};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};

    // A zero divisor already yields all-ones quotient and |rs1| remainder; only skip the quotient negate.
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_step : acc_step;
    quot_fix = ((sign_a_q ^ sign_b_q) && !div_zero_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = sign_a_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;

    if (start) begin
      op_d       = mdu_opcode;
      sign_a_d   = neg_a;
      sign_b_d   = neg_b;
      div_zero_d = (mdu_rs2 == '0);
      opnd_d     = mdu_opcode[2] ? mag_b : mag_a;
      acc_d      = {{XLEN{1'b0}}, (mdu_opcode[2] ? mag_a : mag_b)};
      cnt_d      = 5'd31;
    end else if (state_q == BUSY) begin
      acc_d = acc_step;
      cnt_d = cnt_q - 5'd1;
    end

    if (last) begin
      case (op_q)
        3'd0:       result_d = prod_fix[XLEN-1:0];
        3'd4, 3'd5: result_d = quot_fix;
        3'd6, 3'd7: result_d = rem_fix;
        default:    result_d = prod_fix[2*XLEN-1:XLEN];
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: vector table through the full 33-cycle
// handshake, plus flush, hold and mid-operation reset sequences.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdu_req;
  logic [2:0]  mdu_opcode;
  logic [31:0] mdu_rs1, mdu_rs2;
  logic        ex_flush, ex_hold;
  logic        mdu_stall_req, mdu_done;
  logic [31:0] mdu_result;

  int n_pass  = 0;
  int n_total = 0;

  ex_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .mdu_req(mdu_req), .mdu_opcode(mdu_opcode),
    .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2), .ex_flush(ex_flush), .ex_hold(ex_hold),
    .mdu_stall_req(mdu_stall_req), .mdu_done(mdu_done), .mdu_result(mdu_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Advance to the next cycle: drive inputs just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check the 33-cycle handshake and the result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int bad;
    next_cycle();
    mdu_req = 1'b1; mdu_opcode = op; mdu_rs1 = a; mdu_rs2 = b;
    @(negedge clk);
    check({name, " stall_c0"}, {31'b0, mdu_stall_req}, 32'd1);
    next_cycle();
    mdu_req = 1'b0; mdu_opcode = ~op; mdu_rs1 = ~a; mdu_rs2 = ~b;
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (mdu_stall_req !== 1'b1 || mdu_done !== 1'b0) bad++;
      next_cycle();
    end
    check({name, " busy_cycles_bad"}, bad, 32'd0);
    @(negedge clk);
    check({name, " done_c33"}, {31'b0, mdu_done}, 32'd1);
    check({name, " result"}, mdu_result, exp);
    check({name, " stall_done"}, {31'b0, mdu_stall_req}, 32'd0);
    next_cycle();
    @(negedge clk);
    check({name, " idle_after"}, {31'b0, mdu_done}, 32'd0);
  endtask

  initial begin
    int bad;
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3"};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max"};
    vecs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min"};
    vecs[3]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "MULH -1*-1"};
    vecs[4]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "MULHSU -1*2"};
    vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "MULHSU min*umax"};
    vecs[6]  = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "MUL shift"};
    vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV overflow"};
    vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "REM overflow"};
    vecs[9]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "DIV -7/2"};
    vecs[10] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "REM -7/2"};
    vecs[11] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "DIV 7/-2"};
    vecs[12] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "REM 7/-2"};
    vecs[13] = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "DIVU 5/0"};
    vecs[14] = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "REMU 5/0"};
    vecs[15] = '{3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, "DIV -5/0"};
    vecs[16] = '{3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, "REM -5/0"};
    vecs[17] = '{3'd5, 32'd100,       32'd7,         32'h0000_000E, "DIVU 100/7"};

    rst = 1'b1; mdu_req = 1'b0; mdu_opcode = 3'd0; mdu_rs1 = '0; mdu_rs2 = '0;
    ex_flush = 1'b0; ex_hold = 1'b0;
    #1;
    mdu_req = 1'b1;
    #1;
    check("reset stall", {31'b0, mdu_stall_req}, 32'd0);
    check("reset done", {31'b0, mdu_done}, 32'd0);
    check("reset result", mdu_result, 32'd0);
    mdu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Flush in the 10th BUSY cycle, then IDLE, then a fresh request completes.
    next_cycle();
    mdu_req = 1'b1; mdu_opcode = 3'd0; mdu_rs1 = 32'd9; mdu_rs2 = 32'd9;
    next_cycle();
    mdu_req = 1'b0;
    for (int c = 1; c < 10; c++) next_cycle();
    ex_flush = 1'b1;
    @(negedge clk);
    check("flush stall", {31'b0, mdu_stall_req}, 32'd0);
    check("flush done", {31'b0, mdu_done}, 32'd0);
    next_cycle();
    ex_flush = 1'b0;
    @(negedge clk);
    check("flush idle stall", {31'b0, mdu_stall_req}, 32'd0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mdu_done !== 1'b0 || mdu_stall_req !== 1'b0) bad++;
    end
    check("flush no result", bad, 32'd0);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, "REMU after flush");

    // Hold DONE for 3 cycles; a request there must not start anything.
    next_cycle();
    mdu_req = 1'b1; mdu_opcode = 3'd0; mdu_rs1 = 32'd6; mdu_rs2 = 32'd7;
    next_cycle();
    mdu_req = 1'b0;
    for (int c = 1; c <= 32; c++) next_cycle();
    ex_hold = 1'b1; mdu_req = 1'b1; mdu_opcode = 3'd4;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) ex_hold = 1'b0;
      @(negedge clk);
      if (mdu_done !== 1'b1 || mdu_result !== 32'd42 || mdu_stall_req !== 1'b0) bad++;
      next_cycle();
    end
    mdu_req = 1'b0;
    check("hold stable cycles bad", bad, 32'd0);
    @(negedge clk);
    check("hold then idle", {31'b0, mdu_done}, 32'd0);
    check("hold idle stall", {31'b0, mdu_stall_req}, 32'd0);

    // Reset pulse in the 5th BUSY cycle.
    next_cycle();
    mdu_req = 1'b1; mdu_opcode = 3'd3; mdu_rs1 = 32'hFFFF_FFFF; mdu_rs2 = 32'd3;
    next_cycle();
    mdu_req = 1'b0;
    for (int c = 1; c < 5; c++) next_cycle();
    mdu_req = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst stall", {31'b0, mdu_stall_req}, 32'd0);
    check("midrst done", {31'b0, mdu_done}, 32'd0);
    check("midrst result", mdu_result, 32'd0);
    @(negedge clk);
    mdu_req = 1'b0;
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mdu_done !== 1'b0 || mdu_stall_req !== 1'b0) bad++;
    end
    check("midrst no result", bad, 32'd0);
    run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, "MULH after rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
